// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback buffer: entry layout, drain FSM states and
// the register address width.
package regfile_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  // Storage width of an entry; the buffer's DATA_WIDTH must not exceed this.
  localparam int unsigned WB_DATA_W  = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/regfile_wb_buffer_if.sv
// Writeback channel (results in) and register-file write port (results out) of the buffer.
interface regfile_wb_buffer_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  import regfile_wb_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  stall;
  logic                  we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  // master: execution units plus the register file; slave: the buffer.
  modport master (
    output in_valid, in_addr, in_data, stall,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_valid, in_addr, in_data, stall,
    output in_ready, we, waddr, wdata
  );

endinterface

// File: rtl/wb_bypass_match.sv
// Youngest-match lookup of one read address across all valid buffer entries.
module wb_bypass_match
  import regfile_wb_pkg::*;
#(
  parameter int unsigned Depth       = 4,
  parameter int unsigned DataWidth   = 64,
  parameter bit          ZeroRegZero = 1'b1
) (
  input  wb_entry_t [Depth-1:0]         entries_i,
  input  logic      [Depth-1:0]         valid_i,
  input  logic      [$clog2(Depth)-1:0] wr_idx_i,
  input  logic      [REG_ADDR_W-1:0]    addr_i,
  output logic                          hit_o,
  output logic      [DataWidth-1:0]     data_o
);

  localparam int unsigned IdxW = $clog2(Depth);

  logic [IdxW-1:0] idx;

  // Walk backwards from the slot just below the write index: first match is the youngest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 1; k <= int'(Depth); k++) begin
      idx = wr_idx_i - IdxW'(k);
      if (!hit_o && valid_i[idx] && (entries_i[idx].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data[DataWidth-1:0];
      end
    end
    if (ZeroRegZero && (addr_i == '0)) begin
      hit_o  = 1'b0;
      data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Queues writeback results, drains them onto one register-file write port, forwards pending
// values to readers and supports a drain-and-quiesce flush.
module regfile_wb_buffer
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned NR_READ_PORTS = 2,
  parameter bit          ZERO_REG_ZERO = 1'b1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  output logic                                      flush_done_o,
  regfile_wb_buffer_if.slave                        wb,
  input  logic [NR_READ_PORTS-1:0][REG_ADDR_W-1:0]  byp_addr_i,
  output logic [NR_READ_PORTS-1:0]                  byp_hit_o,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  byp_data_o,
  output logic [$clog2(DEPTH):0]                    count_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic      [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic      [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic      [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  state_e                state_q, state_d;

  logic            empty, full, pop, accept, push;
  logic [IdxW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);

  assign wb.we    = !empty && !wb.stall;
  assign wb.waddr = mem_q[rd_idx].addr;
  assign wb.wdata = mem_q[rd_idx].data[DATA_WIDTH-1:0];
  assign pop      = wb.we;

  assign wb.in_ready = (state_q == StRun) && (!full || pop);
  assign accept      = wb.in_valid && wb.in_ready;
  // x0 results complete the handshake but are dropped.
  assign push        = accept && !(ZERO_REG_ZERO && (wb.in_addr == '0));

  assign count_o = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (pop) begin
      valid_d[rd_idx] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    // Applied after the pop so a push into the slot being freed (full case) wins.
    if (push) begin
      mem_d[wr_idx].addr = wb.in_addr;
      mem_d[wr_idx].data = WB_DATA_W'(wb.in_data);
      valid_d[wr_idx]    = 1'b1;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    unique case (state_q)
      StRun: begin
        if (flush_i) begin
          state_d = (empty && !push) ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        flush_done_o = 1'b1;
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      state_q  <= StRun;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
    end
  end

  // Payload needs no reset: valid bits and pointers gate every use of it.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  for (genvar p = 0; p < int'(NR_READ_PORTS); p++) begin : g_byp
    wb_bypass_match #(
      .Depth      (DEPTH),
      .DataWidth  (DATA_WIDTH),
      .ZeroRegZero(ZERO_REG_ZERO)
    ) u_match (
      .entries_i(mem_q),
      .valid_i  (valid_q),
      .wr_idx_i (wr_idx),
      .addr_i   (byp_addr_i[p]),
      .hit_o    (byp_hit_o[p]),
      .data_o   (byp_data_o[p])
    );
  end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed and random stimulus for regfile_wb_buffer, checked every cycle against a
// queue-based reference model.
module tb_regfile_wb_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             flush;
  logic             flush_done;
  logic [1:0][4:0]  byp_addr;
  logic [1:0]       byp_hit;
  logic [1:0][63:0] byp_data;
  logic [2:0]       count;

  regfile_wb_buffer_if #(.DATA_WIDTH(64)) wb_if ();

  regfile_wb_buffer #(
    .DATA_WIDTH   (64),
    .DEPTH        (4),
    .NR_READ_PORTS(2),
    .ZERO_REG_ZERO(1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .flush_done_o(flush_done),
    .wb          (wb_if),
    .byp_addr_i  (byp_addr),
    .byp_hit_o   (byp_hit),
    .byp_data_o  (byp_data),
    .count_o     (count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ment_t;

  ment_t q[$];
  int    mstate   = 0;    // 0 = run, 1 = drain, 2 = done
  bit    model_ok = 1'b0;  // model state is meaningful only after the first reset

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock: drive at the falling edge, check settled outputs, then advance the model.
  task automatic cycle(input logic v, input logic [4:0] a, input logic [63:0] d,
                       input logic st, input logic fl, input logic r,
                       input logic [4:0] b0, input logic [4:0] b1);
    bit          exp_we, exp_ready, do_push;
    bit   [1:0]  exp_hit;
    logic [63:0] exp_d [2];
    logic [4:0]  ba;
    int          sz;
    wb_if.in_valid = v;
    wb_if.in_addr  = a;
    wb_if.in_data  = d;
    wb_if.stall    = st;
    flush          = fl;
    rst            = r;
    byp_addr[0]    = b0;
    byp_addr[1]    = b1;
    #1;
    sz        = q.size();
    exp_we    = (sz != 0) && !st;
    exp_ready = (mstate == 0) && ((sz < 4) || exp_we);
    for (int p = 0; p < 2; p++) begin
      ba         = (p == 0) ? b0 : b1;
      exp_hit[p] = 1'b0;
      exp_d[p]   = '0;
      if (ba != 0) begin
        for (int i = sz - 1; i >= 0; i--) begin
          if (q[i].a == ba) begin
            exp_hit[p] = 1'b1;
            exp_d[p]   = q[i].d;
            break;
          end
        end
      end
    end
    if (model_ok) begin
      check_val("we", 64'(wb_if.we), 64'(exp_we));
      if (exp_we) begin
        check_val("waddr", 64'(wb_if.waddr), 64'(q[0].a));
        check_val("wdata", wb_if.wdata, q[0].d);
      end
      check_val("in_ready", 64'(wb_if.in_ready), 64'(exp_ready));
      check_val("count", 64'(count), 64'(sz));
      check_val("flush_done", 64'(flush_done), 64'(mstate == 2));
      check_val("byp_hit0", 64'(byp_hit[0]), 64'(exp_hit[0]));
      check_val("byp_data0", byp_data[0], exp_d[0]);
      check_val("byp_hit1", 64'(byp_hit[1]), 64'(exp_hit[1]));
      check_val("byp_data1", byp_data[1], exp_d[1]);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      mstate   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      do_push = v && exp_ready && (a != 0);
      if (exp_we) void'(q.pop_front());
      if (do_push) q.push_back('{a: a, d: d});
      case (mstate)
        0: if (fl) mstate = (sz == 0 && !do_push) ? 2 : 1;
        1: if (sz == 0) mstate = 2;
        default: mstate = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 64'd0, st, 1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
  endtask

  initial begin
    wb_if.in_valid = 1'b0;
    wb_if.in_addr  = '0;
    wb_if.in_data  = '0;
    wb_if.stall    = 1'b0;
    flush          = 1'b0;
    rst            = 1'b1;
    byp_addr       = '0;
    @(negedge clk);
    do_reset();
    idle(1, 1'b0);

    // Single push drains on the next cycle.
    cycle(1'b1, 5'd5, 64'hAA, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
    idle(2, 1'b0);

    // Fill under stall, refuse a fifth, then push into a full buffer while draining.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 64'(i * 16), 1'b1, 1'b0, 1'b0, 5'd3, 5'd4);
    cycle(1'b1, 5'd6, 64'h66, 1'b1, 1'b0, 1'b0, 5'd6, 5'd1);
    cycle(1'b1, 5'd9, 64'h99, 1'b0, 1'b0, 1'b0, 5'd9, 5'd2);
    idle(5, 1'b0);

    // Youngest pending value wins the bypass.
    cycle(1'b1, 5'd7, 64'h11, 1'b1, 1'b0, 1'b0, 5'd7, 5'd8);
    cycle(1'b1, 5'd7, 64'h22, 1'b1, 1'b0, 1'b0, 5'd7, 5'd8);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd8);
    idle(3, 1'b0);

    // Writes to x0 are accepted and dropped.
    cycle(1'b1, 5'd0, 64'hFF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(2, 1'b0);

    // Flush with two pending entries held by a stall.
    cycle(1'b1, 5'd10, 64'hA0, 1'b1, 1'b0, 1'b0, 5'd10, 5'd11);
    cycle(1'b1, 5'd11, 64'hB0, 1'b1, 1'b0, 1'b0, 5'd10, 5'd11);
    cycle(1'b1, 5'd12, 64'hC0, 1'b1, 1'b1, 1'b0, 5'd10, 5'd11);
    cycle(1'b1, 5'd12, 64'hC1, 1'b1, 1'b1, 1'b0, 5'd10, 5'd11);
    idle(1, 1'b1);
    idle(5, 1'b0);

    // Flush when already empty.
    cycle(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    idle(2, 1'b0);

    // Reset in the middle of a drain discards pending entries.
    cycle(1'b1, 5'd13, 64'hD0, 1'b1, 1'b0, 1'b0, 5'd13, 5'd0);
    cycle(1'b1, 5'd14, 64'hE0, 1'b1, 1'b1, 1'b0, 5'd13, 5'd14);
    idle(1, 1'b1);
    cycle(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 5'd13, 5'd14);
    idle(3, 1'b0);

    // Random traffic over a small address range so bypass hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 199) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
